freq_classifier: RTL

- Upstream stage of the frequency-response path; drives the `frequency` code consumed by the command decoder (hear_freq logic).
- Synchronises the raw `mic` comparator output and counts rising edges over fixed quarter-second windows.
- Classifies each window into a 2-bit tone code and checks that 8 consecutive windows agree.
- Publishes one registered code plus a 1-cycle `valid` strobe per 8-window measurement, repeating while `enable` is high.

---
 rtl/freq_pkg.sv | 28 ++
 rtl/mic_edge_detect.sv | 70 +++++++
 rtl/freq_classifier.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared tone codes, FSM state encoding and the edge-count classifier for freq_classifier.
package freq_pkg;

    localparam logic [1:0] FREQ_NONE = 2'd0;
    localparam logic [1:0] FREQ_500  = 2'd1;
    localparam logic [1:0] FREQ_1000 = 2'd2;
    localparam logic [1:0] FREQ_1500 = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCount  = 2'd1,
        StDecide = 2'd2
    } state_e;

    // Bands are checked lowest first so an overlap resolves to the lower code.
    function automatic logic [1:0] classify(
        input int unsigned count,
        input int unsigned b1_lo, input int unsigned b1_hi,
        input int unsigned b2_lo, input int unsigned b2_hi,
        input int unsigned b3_lo, input int unsigned b3_hi
    );
        if (count >= b1_lo && count <= b1_hi) return FREQ_500;
        if (count >= b2_lo && count <= b2_hi) return FREQ_1000;
        if (count >= b3_lo && count <= b3_hi) return FREQ_1500;
        return FREQ_NONE;
    endfunction

endpackage

// File: rtl/mic_edge_detect.sv
// Synchronises the raw mic comparator and emits a registered 1-cycle rising-edge pulse.
// FREQ_CLASSIFIER_DEBOUNCE_EN inserts a DEB_CYCLES glitch filter ahead of the edge detect.
module mic_edge_detect
`ifdef FREQ_CLASSIFIER_DEBOUNCE_EN
#(
    parameter int unsigned DEB_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic i_mic,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_lvl_q;
    logic r_edge;
    logic w_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_mic;
            r_sync <= r_meta;
        end
    end

`ifdef FREQ_CLASSIFIER_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_filt;

    // The filtered level follows only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= '0;
            r_filt    <= 1'b0;
        end else if (r_sync == r_filt) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            r_deb_cnt <= '0;
            r_filt    <= r_sync;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_q <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_lvl_q <= w_lvl;
            r_edge  <= w_lvl & ~r_lvl_q;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/freq_classifier.sv
// Counts mic rising edges over NUM_WINDOWS windows, votes on the per-window code and publishes
// one registered frequency code with a valid strobe. Optional: FREQ_CLASSIFIER_DEBOUNCE_EN.
module freq_classifier
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned WINDOW_CYCLES = CLK_HZ / 4,
    parameter int unsigned NUM_WINDOWS   = 8,
    parameter int unsigned CNT_W         = 10,
    parameter int unsigned B1_LO         = 113,
    parameter int unsigned B1_HI         = 137,
    parameter int unsigned B2_LO         = 238,
    parameter int unsigned B2_HI         = 262,
    parameter int unsigned B3_LO         = 363,
    parameter int unsigned B3_HI         = 387
`ifdef FREQ_CLASSIFIER_DEBOUNCE_EN
    ,
    parameter int unsigned DEB_CYCLES    = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mic,
    output logic [1:0] frequency,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned CYC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned WIN_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NUM_WINDOWS - 1);

    state_e           r_state, w_state_nxt;
    logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
    logic [WIN_W-1:0] r_win, w_win_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_match, w_match_nxt;
    logic [1:0]       r_ref, w_ref_nxt;
    logic [1:0]       r_freq, w_freq_nxt;
    logic             r_valid, w_valid_nxt;

    logic             w_edge;
    logic [CNT_W-1:0] w_cnt_total;
    logic [1:0]       w_code;
    logic             w_last_cyc;

    mic_edge_detect
`ifdef FREQ_CLASSIFIER_DEBOUNCE_EN
    #(
        .DEB_CYCLES (DEB_CYCLES)
    )
`endif
    u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_mic  (mic),
        .o_edge (w_edge)
    );

    // An edge on the final cycle of a window is still credited to that window.
    assign w_cnt_total = (w_edge && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
    assign w_code      = classify(32'(w_cnt_total), B1_LO, B1_HI, B2_LO, B2_HI, B3_LO, B3_HI);
    assign w_last_cyc  = (r_cyc == CYC_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_win_nxt   = r_win;
        w_cnt_nxt   = r_cnt;
        w_match_nxt = r_match;
        w_ref_nxt   = r_ref;
        w_freq_nxt  = r_freq;
        w_valid_nxt = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_nxt = StCount;
                    w_cyc_nxt   = '0;
                    w_win_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_match_nxt = 1'b1;
                end
            end
            StCount: begin
                if (!enable) begin
                    w_state_nxt = StIdle;
                    w_freq_nxt  = FREQ_NONE;
                end else begin
                    w_cnt_nxt = w_cnt_total;
                    w_cyc_nxt = r_cyc + 1'b1;
                    if (w_last_cyc) begin
                        w_cyc_nxt = '0;
                        w_cnt_nxt = '0;
                        if (r_win == '0) begin
                            w_ref_nxt = w_code;
                        end
                        if ((w_code == FREQ_NONE) || ((r_win != '0) && (w_code != r_ref))) begin
                            w_match_nxt = 1'b0;
                        end
                        if (r_win == WIN_LAST) begin
                            w_state_nxt = StDecide;
                        end else begin
                            w_win_nxt = r_win + 1'b1;
                        end
                    end
                end
            end
            StDecide: begin
                if (!enable) begin
                    w_state_nxt = StIdle;
                    w_freq_nxt  = FREQ_NONE;
                end else begin
                    w_freq_nxt  = r_match ? r_ref : FREQ_NONE;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = StCount;
                    w_cyc_nxt   = '0;
                    w_win_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_match_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cyc   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_ref   <= FREQ_NONE;
            r_freq  <= FREQ_NONE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_win   <= w_win_nxt;
            r_cnt   <= w_cnt_nxt;
            r_match <= w_match_nxt;
            r_ref   <= w_ref_nxt;
            r_freq  <= w_freq_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign frequency = r_freq;
    assign valid     = r_valid;
    assign busy      = (r_state != StIdle);

endmodule
